// File: rtl/traffic_ctrl_nway.sv
// N-approach round-robin traffic signal controller with demand skipping and
// emergency pre-emption. Outputs are a pure decode of the phase/dir/timer flops.
//
// state     | meaning
// ----------+-----------------------------------------------------
// PH_ALLRED | every head red; clearance before choosing next_dir
// PH_GREEN  | cur_dir green, others red
// PH_YELLOW | cur_dir yellow, others red
module traffic_ctrl_nway #(
    parameter int N_APPR   = 4,
    parameter int GREEN_T  = 30,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 2,
    parameter int CNT_W    = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_APPR-1:0]           i_veh_present,
    input  logic                        i_emerg_req,
    input  logic [$clog2(N_APPR)-1:0]   i_emerg_dir,
    output logic [3*N_APPR-1:0]         o_lights,
    output logic [$clog2(N_APPR)-1:0]   o_green_dir,
    output logic [1:0]                  o_phase
);
    localparam int DIR_W = $clog2(N_APPR);
    localparam logic [DIR_W:0]   N_DIR  = N_APPR[DIR_W:0];
    localparam logic [DIR_W-1:0] LAST   = DIR_W'(N_APPR - 1);
    localparam logic [CNT_W-1:0] G_LD   = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] Y_LD   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] A_LD   = CNT_W'(ALLRED_T - 1);

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    phase_t           r_phase;
    logic [DIR_W-1:0] r_cur_dir;
    logic [CNT_W-1:0] r_tmr;

    logic             w_emerg_vld;
    logic             w_scan_hit;
    logic [DIR_W-1:0] w_scan_dir;
    logic [DIR_W-1:0] w_rr_dir;
    logic [DIR_W-1:0] w_next_dir;

    assign w_emerg_vld = i_emerg_req && ({1'b0, i_emerg_dir} < N_DIR);
    assign w_rr_dir    = DIR_W'((int'(r_cur_dir) + 1) % N_APPR);

    // Scan from the far end so the nearest requester after cur_dir wins;
    // cur_dir itself is offset N_APPR, i.e. considered last.
    always_comb begin
        w_scan_hit = 1'b0;
        w_scan_dir = '0;
        for (int k = N_APPR; k >= 1; k--) begin
            if (i_veh_present[(int'(r_cur_dir) + k) % N_APPR]) begin
                w_scan_hit = 1'b1;
                w_scan_dir = DIR_W'((int'(r_cur_dir) + k) % N_APPR);
            end
        end
    end

    always_comb begin
        if (w_emerg_vld)
            w_next_dir = i_emerg_dir;
        else if (w_scan_hit)
            w_next_dir = w_scan_dir;
        else
            w_next_dir = w_rr_dir;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase   <= PH_ALLRED;
            r_cur_dir <= LAST;
            r_tmr     <= A_LD;
        end else begin
            case (r_phase)
                PH_GREEN: begin
                    if (w_emerg_vld && (i_emerg_dir != r_cur_dir)) begin
                        r_phase <= PH_YELLOW;
                        r_tmr   <= Y_LD;
                    end else if (w_emerg_vld) begin
                        r_tmr   <= G_LD;
                    end else if (r_tmr == '0) begin
                        r_phase <= PH_YELLOW;
                        r_tmr   <= Y_LD;
                    end else begin
                        r_tmr   <= r_tmr - 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (r_tmr == '0) begin
                        r_phase <= PH_ALLRED;
                        r_tmr   <= A_LD;
                    end else begin
                        r_tmr   <= r_tmr - 1'b1;
                    end
                end
                default: begin
                    if (r_tmr == '0) begin
                        r_phase   <= PH_GREEN;
                        r_cur_dir <= w_next_dir;
                        r_tmr     <= G_LD;
                    end else begin
                        r_tmr     <= r_tmr - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_lights = {N_APPR{3'b100}};
        if (r_phase == PH_GREEN)
            o_lights[3*int'(r_cur_dir) +: 3] = 3'b001;
        else if (r_phase == PH_YELLOW)
            o_lights[3*int'(r_cur_dir) +: 3] = 3'b010;
    end

    assign o_green_dir = r_cur_dir;
    assign o_phase     = r_phase;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Scoreboard bench for traffic_ctrl_nway: a 4-way and a 3-way instance share
// stimulus; an elapsed-time reference model predicts every cycle's outputs.
module tb_traffic_ctrl_nway;
    localparam int GT = 5;
    localparam int YT = 2;
    localparam int AT = 1;

    typedef struct packed {
        logic [11:0] lights;
        logic [1:0]  dir;
        logic [1:0]  phase;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  veh = 4'b0;
    logic        ereq = 1'b0;
    logic [1:0]  edir = 2'd0;

    logic [11:0] lights0;
    logic [1:0]  gdir0;
    logic [1:0]  phase0;
    logic [8:0]  lights1;
    logic [1:0]  gdir1;
    logic [1:0]  phase1;

    traffic_ctrl_nway #(.N_APPR(4), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .CNT_W(8)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_veh_present(veh), .i_emerg_req(ereq), .i_emerg_dir(edir),
        .o_lights(lights0), .o_green_dir(gdir0), .o_phase(phase0));

    traffic_ctrl_nway #(.N_APPR(3), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .CNT_W(8)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_veh_present(veh[2:0]), .i_emerg_req(ereq), .i_emerg_dir(edir),
        .o_lights(lights1), .o_green_dir(gdir1), .o_phase(phase1));

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    // model state per instance: phase (0 allred, 1 green, 2 yellow), owner, cycles elapsed in phase
    int na[2] = '{4, 3};
    int mp[2];
    int md[2];
    int me[2];

    function automatic int pick_dir(input int n, input int cur, input logic [3:0] v);
        int best  = -1;
        int bestd = n;
        for (int i = 0; i < n; i++) begin
            int d = (i - cur - 1 + n) % n;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return (best < 0) ? (cur + 1) % n : best;
    endfunction

    task automatic model_step(input int k, input bit r, input logic [3:0] v, input bit e, input int ed);
        int n   = na[k];
        bit ev  = e && (ed < n);
        if (r) begin
            mp[k] = 0; md[k] = n - 1; me[k] = 0;
        end else if (mp[k] == 1) begin
            if (ev && ed != md[k]) begin mp[k] = 2; me[k] = 0; end
            else if (ev)           me[k] = 0;
            else if (me[k] == GT-1) begin mp[k] = 2; me[k] = 0; end
            else                   me[k]++;
        end else if (mp[k] == 2) begin
            if (me[k] == YT-1) begin mp[k] = 0; me[k] = 0; end
            else               me[k]++;
        end else begin
            if (me[k] == AT-1) begin
                mp[k] = 1; me[k] = 0;
                md[k] = ev ? ed : pick_dir(n, md[k], v);
            end else me[k]++;
        end
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t x;
        logic [2:0] h;
        x.lights = '0;
        for (int i = 0; i < na[k]; i++) begin
            h = 3'b100;
            if (i == md[k] && mp[k] == 1) h = 3'b001;
            if (i == md[k] && mp[k] == 2) h = 3'b010;
            x.lights[3*i +: 3] = h;
        end
        x.dir   = md[k][1:0];
        x.phase = mp[k][1:0];
        return x;
    endfunction

    task automatic cyc(input bit r, input logic [3:0] v, input bit e, input logic [1:0] d);
        @(negedge clk);
        rst = r; veh = v; ereq = e; edir = d;
        for (int k = 0; k < 2; k++) model_step(k, r, v, e, int'(d));
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    function automatic int non_red(input logic [11:0] l, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (l[3*i +: 3] != 3'b100) c++;
        return c;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("n4_lights", lights0, e.lights);
                chk("n4_green_dir", {10'b0, gdir0}, {10'b0, e.dir});
                chk("n4_phase", {10'b0, phase0}, {10'b0, e.phase});
                chk("n4_one_non_red", (non_red(lights0, 4) <= 1) ? 12'd1 : 12'd0, 12'd1);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("n3_lights", {3'b0, lights1}, e.lights);
                chk("n3_green_dir", {10'b0, gdir1}, {10'b0, e.dir});
                chk("n3_phase", {10'b0, phase1}, {10'b0, e.phase});
            end
        end
    end

    initial begin
        logic [3:0] v;
        bit         e;
        logic [1:0] d;

        // reset, then plain round-robin with no demand
        cyc(1, 4'b0000, 0, 0);
        cyc(1, 4'b0000, 0, 0);
        repeat (64) cyc(0, 4'b0000, 0, 0);

        // lone demand on dir2 is re-served
        cyc(1, 4'b0100, 0, 0);
        repeat (40) cyc(0, 4'b0100, 0, 0);

        // all demand; pre-empt to dir3 during dir0 green, hold, then drop
        cyc(1, 4'b1111, 0, 0);
        repeat (2) cyc(0, 4'b1111, 0, 0);
        repeat (14) cyc(0, 4'b1111, 1, 2'd3);
        repeat (12) cyc(0, 4'b1111, 0, 2'd3);

        // emerg_dir=3 is out of range for the 3-way build only
        cyc(1, 4'b0000, 0, 0);
        repeat (40) cyc(0, 4'b0000, 1, 2'd3);

        // reset in the middle of dir1 yellow
        cyc(1, 4'b0000, 0, 0);
        repeat (14) cyc(0, 4'b0000, 0, 0);
        cyc(1, 4'b0000, 0, 0);
        repeat (10) cyc(0, 4'b0000, 0, 0);

        // randomized traffic, emergencies and occasional resets
        e = 0; d = 0;
        for (int i = 0; i < 800; i++) begin
            v = 4'($urandom);
            if ($urandom_range(0, 3) == 0) v = 4'b0000;
            if ($urandom_range(0, 24) == 0) e = ~e;
            if ($urandom_range(0, 9) == 0)  d = 2'($urandom);
            cyc(($urandom_range(0, 99) == 0), v, e, d);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 12'(q0.size() + q1.size()), 12'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
